// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the RV32I control path.
// State, opcode, ALU operation and datapath mux-select codes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_MEM    = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;

  localparam logic [1:0] SRCB_RS2 = 2'd0;
  localparam logic [1:0] SRCB_IMM = 2'd1;
  localparam logic [1:0] SRCB_4   = 2'd2;

endpackage

// File: rtl/riscv_mc_control_if.sv
// Control <-> datapath/memory bundle for the multicycle core.
// master = control FSM, slave = datapath and memory side.
interface riscv_mc_control_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             MemWrite;
  logic             AdrSrc;
  logic             IRWrite;
  logic             PCWrite;
  logic             RegWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ImmSrc;
  logic [3:0]       ALU_operation;
  logic             illegal;
  logic             retire;
  logic [CNT_W-1:0] retired_cnt;

  modport master (
    input  instr, zero, mem_ready,
    output mem_req, MemWrite, AdrSrc,
    output IRWrite, PCWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB,
    output ImmSrc, ALU_operation,
    output illegal, retire, retired_cnt
  );

  modport slave (
    output instr, zero, mem_ready,
    input  mem_req, MemWrite, AdrSrc,
    input  IRWrite, PCWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB,
    input  ImmSrc, ALU_operation,
    input  illegal, retire, retired_cnt
  );
endinterface

// File: rtl/alu_op_decode.sv
// ALU operation and legality decode from state and instruction fields.
// Shared with the single-cycle control variant.
module alu_op_decode
  import riscv_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output logic [3:0] o_alu_op,
  output logic       o_illegal
);

  logic       w_is_r;
  logic       w_f7_ok;
  logic [3:0] w_arith_op;
  logic       w_arith_bad;

  assign w_is_r  = (i_opcode == OP_R);
  // only SUB may set funct7[5]; every other funct7 bit must be clear
  assign w_f7_ok = (i_funct7 == 7'b0000000) ||
                   ((i_funct7 == 7'b0100000) &&
                    (i_funct3 == 3'b000));

  always_comb begin
    w_arith_op  = ALU_ADD;
    w_arith_bad = 1'b0;
    unique case (i_funct3)
      3'b000: w_arith_op = (w_is_r && i_funct7[5]) ?
                           ALU_SUB : ALU_ADD;
      3'b111: w_arith_op = ALU_AND;
      3'b110: w_arith_op = ALU_OR;
      3'b100: w_arith_op = ALU_XOR;
      default: w_arith_bad = 1'b1;
    endcase
  end

  always_comb begin
    o_illegal = 1'b1;
    unique case (1'b1)
      i_opcode == OP_R:
        o_illegal = w_arith_bad || !w_f7_ok;
      i_opcode == OP_I:
        o_illegal = w_arith_bad;
      (i_opcode == OP_LW) || (i_opcode == OP_SW):
        o_illegal = (i_funct3 != 3'b010);
      i_opcode == OP_BR:
        o_illegal = (i_funct3[2:1] != 2'b00);
      i_opcode == OP_JAL:
        o_illegal = 1'b0;
      default:
        o_illegal = 1'b1;
    endcase
  end

  always_comb begin
    o_alu_op = ALU_ADD;
    unique case (i_state)
      S_EXECR, S_EXECI: o_alu_op = w_arith_op;
      S_BRANCH:         o_alu_op = ALU_SUB;
      default:          o_alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mc_control.sv
// Multicycle RV32I control FSM: fetch/decode/execute/mem/writeback
// sequencing, memory handshake hold and retired-instruction counter.
module riscv_mc_control
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W                 = 32,
  parameter bit RESET_TO_ILLEGAL_LOCK = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  riscv_mc_control_if.master bus
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [6:0]       w_opcode;
  logic [2:0]       w_funct3;
  logic [6:0]       w_funct7;
  logic [3:0]       w_alu_op;
  logic             w_bad;
  logic             w_retire;
  logic             w_unused;

  assign w_opcode = bus.instr[6:0];
  assign w_funct3 = bus.instr[14:12];
  assign w_funct7 = bus.instr[31:25];
  assign w_unused = ^{bus.instr[24:15], bus.instr[11:7]};

  alu_op_decode u_dec (
    .i_state  (r_state),
    .i_opcode (w_opcode),
    .i_funct3 (w_funct3),
    .i_funct7 (w_funct7),
    .o_alu_op (w_alu_op),
    .o_illegal(w_bad)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    unique case (r_state)
      S_FETCH:
        w_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (w_bad) w_next = S_ILLEGAL;
        else begin
          unique case (w_opcode)
            OP_LW, OP_SW: w_next = S_MEMADR;
            OP_R:         w_next = S_EXECR;
            OP_I:         w_next = S_EXECI;
            OP_BR:        w_next = S_BRANCH;
            default:      w_next = S_JAL;
          endcase
        end
      end
      S_MEMADR:
        w_next = (w_opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:
        w_next = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE:
        w_next = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_JAL:
        w_next = S_ALUWB;
      S_ILLEGAL:
        w_next = RESET_TO_ILLEGAL_LOCK ? S_ILLEGAL : S_FETCH;
      default:
        w_next = S_FETCH;
    endcase
  end

  // everything is held at zero while reset is asserted
  always_comb begin
    bus.mem_req       = 1'b0;
    bus.MemWrite      = 1'b0;
    bus.AdrSrc        = 1'b0;
    bus.IRWrite       = 1'b0;
    bus.PCWrite       = 1'b0;
    bus.RegWrite      = 1'b0;
    bus.ResultSrc     = RES_ALUOUT;
    bus.ALUSrcA       = SRCA_PC;
    bus.ALUSrcB       = SRCB_RS2;
    bus.ImmSrc        = IMM_I;
    bus.ALU_operation = ALU_ADD;
    bus.illegal       = 1'b0;
    w_retire          = 1'b0;
    if (rst_n) begin
      bus.ALU_operation = w_alu_op;
      unique case (r_state)
        S_FETCH: begin
          bus.mem_req   = 1'b1;
          bus.IRWrite   = bus.mem_ready;
          bus.PCWrite   = bus.mem_ready;
          bus.ALUSrcB   = SRCB_4;
          bus.ResultSrc = RES_ALU;
        end
        S_DECODE: begin
          bus.ALUSrcA = SRCA_OLDPC;
          bus.ALUSrcB = SRCB_IMM;
          bus.ImmSrc  = IMM_B;
        end
        S_MEMADR: begin
          bus.ALUSrcA = SRCA_RS1;
          bus.ALUSrcB = SRCB_IMM;
          bus.ImmSrc  = (w_opcode == OP_SW) ? IMM_S : IMM_I;
        end
        S_MEMREAD: begin
          bus.mem_req = 1'b1;
          bus.AdrSrc  = 1'b1;
        end
        S_MEMWB: begin
          bus.RegWrite  = 1'b1;
          bus.ResultSrc = RES_MEM;
          w_retire      = 1'b1;
        end
        S_MEMWRITE: begin
          bus.mem_req  = 1'b1;
          bus.MemWrite = 1'b1;
          bus.AdrSrc   = 1'b1;
          w_retire     = bus.mem_ready;
        end
        S_EXECR: begin
          bus.ALUSrcA = SRCA_RS1;
          bus.ALUSrcB = SRCB_RS2;
        end
        S_EXECI: begin
          bus.ALUSrcA = SRCA_RS1;
          bus.ALUSrcB = SRCB_IMM;
        end
        S_ALUWB: begin
          bus.RegWrite = 1'b1;
          w_retire     = 1'b1;
        end
        S_BRANCH: begin
          bus.ALUSrcA = SRCA_RS1;
          bus.PCWrite = bus.zero ^ w_funct3[0];
          w_retire    = 1'b1;
        end
        S_JAL: begin
          bus.ALUSrcA = SRCA_OLDPC;
          bus.ALUSrcB = SRCB_4;
          bus.ImmSrc  = IMM_J;
          bus.PCWrite = 1'b1;
        end
        S_ILLEGAL:
          bus.illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.retire = w_retire;

  always_ff @(posedge clk) begin
    if (!rst_n)        r_cnt <= '0;
    else if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign bus.retired_cnt = r_cnt;

endmodule

// File: doc/riscv_mc_control.md
Name: riscv_mc_control

Overview:
- Multicycle control FSM for the RV32I core; the producer side of the ALU interface.
- Sequences fetch, decode, execute, memory and writeback for one instruction at a time.
- Drives `ALU_operation` and the datapath mux/enable strobes, and consumes the ALU `zero` flag to resolve branches.
- Holds a memory request until the memory acknowledges it, and counts retired instructions.

Parameters:
- `CNT_W`, 32, width of the retired-instruction counter.
- `RESET_TO_ILLEGAL_LOCK`, 1, when 1 an illegal instruction locks the FSM until reset; when 0 the instruction is skipped (PC advances by 4).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `instr`  in  32  instruction-register output; stable from DECODE until the next FETCH.
- `zero`  in  1  ALU equality flag (A==B).
- `mem_ready`  in  1  memory acknowledge for the current request.
- `mem_req`  out  1  memory access request.
- `MemWrite`  out  1  store strobe; qualifies `mem_req`.
- `AdrSrc`  out  1  memory address select: 0=PC, 1=ALU result register.
- `IRWrite`  out  1  load the instruction register.
- `PCWrite`  out  1  update PC from the result mux.
- `RegWrite`  out  1  register-file write.
- `ResultSrc`  out  2  0=ALU out register, 1=memory data, 2=ALU result (combinational).
- `ALUSrcA`  out  2  0=PC, 1=old PC, 2=rs1.
- `ALUSrcB`  out  2  0=rs2, 1=immediate, 2=constant 4.
- `ImmSrc`  out  3  immediate format: 0=I, 1=S, 2=B, 3=J.
- `ALU_operation`  out  4  0=add, 1=sub, 2=and, 3=or, 4=xor.
- `illegal`  out  1  level; high while the FSM is in ILLEGAL.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `retired_cnt`  out  CNT_W  count of completed instructions.

Behaviour:
- Reset
  - `rst_n` low at a rising edge: state goes to FETCH and `retired_cnt` goes to 0.
  - While `rst_n` is low, every strobe output is forced to 0 (`mem_req`, `MemWrite`, `IRWrite`, `PCWrite`, `RegWrite`, `illegal`, `retire`).
  - While `rst_n` is low, mux selects and `ALU_operation` are forced to 0.
  - Reset mid-instruction abandons the instruction: no write strobe, no retire.
- Outputs are decoded combinationally from the state register and `instr`.
- Decode
  - Opcodes: R=0110011, I=0010011, LW=0000011, SW=0100011, BR=1100011, JAL=1101111.
  - R/I-type `funct3`: 000 gives ALU_op 0; for R-type only, 000 with `funct7[5]`=1 gives 1.
  - R/I-type `funct3`: 111 gives 2, 110 gives 3, 100 gives 4.
  - Branch `funct3`: 000=BEQ, 001=BNE.
  - Anything else is illegal. This includes LW/SW with `funct3`≠010 and `funct7` bits other than bit 5 set on R-type.
- States and transitions
  - FETCH: `mem_req`=1, `AdrSrc`=0.
    - Stays in FETCH while `mem_ready`=0.
    - When `mem_ready`=1: `IRWrite`=1, `PCWrite`=1 (PC+4: `ALUSrcA`=0, `ALUSrcB`=2, op 0, `ResultSrc`=2), then go to DECODE.
  - DECODE: computes the branch target (`ALUSrcA`=1, `ALUSrcB`=1, `ImmSrc`=2, op 0).
    - Next state by opcode: MEMADR (LW/SW), EXECR, EXECI, BRANCH, JAL, or ILLEGAL.
  - MEMADR: rs1 + imm (`ImmSrc`=0 for LW, 1 for SW), op 0. Next is MEMREAD (LW) or MEMWRITE (SW).
  - MEMREAD: `mem_req`=1, `AdrSrc`=1. Waits for `mem_ready`, then goes to MEMWB.
  - MEMWB: `RegWrite`=1, `ResultSrc`=1, `retire`. Next is FETCH.
  - MEMWRITE: `mem_req`=1, `MemWrite`=1, `AdrSrc`=1. Waits for `mem_ready`; on that cycle `retire`, then go to FETCH.
  - EXECR: `ALUSrcA`=2, `ALUSrcB`=0, decoded op. Next is ALUWB.
  - EXECI: `ALUSrcA`=2, `ALUSrcB`=1, `ImmSrc`=0, decoded op. Next is ALUWB.
  - ALUWB: `RegWrite`=1, `ResultSrc`=0, `retire`. Next is FETCH.
  - BRANCH: `ALUSrcA`=2, `ALUSrcB`=0, op 1, `ResultSrc`=0.
    - `PCWrite` = `zero` for BEQ, `~zero` for BNE.
    - `retire`, then go to FETCH.
  - JAL: `ALUSrcA`=1, `ALUSrcB`=2, op 0, `ImmSrc`=3, `PCWrite`=1 (PC to target). Next is ALUWB, which writes PC+4 to rd.
  - ILLEGAL: `illegal`=1, no strobes, no retire.
    - Stays in ILLEGAL when `RESET_TO_ILLEGAL_LOCK`=1.
    - Otherwise goes to FETCH after 1 cycle.
- Latency with zero-wait memory (`mem_ready` high): R/I-type 4 cycles, LW 5, SW 4, BEQ/BNE 3, JAL 4. Each memory wait cycle adds 1.
- `mem_ready` high in a state without `mem_req` is ignored.
- `retired_cnt` increments by 1 on each `retire` and wraps from all-ones to 0.
- Unreachable state encodings go to FETCH on the next edge.

Decomposition:
- Package `riscv_ctrl_pkg` holds:
  - state enum;
  - opcode localparams;
  - ALU_operation localparams (ADD=0, SUB=1, AND=2, OR=3, XOR=4);
  - ImmSrc, ResultSrc, ALUSrcA and ALUSrcB encodings.
- One sub-module, `alu_op_decode`: combinational mapping of (state, opcode, `funct3`, `funct7[5]`) to `ALU_operation` plus an illegal flag. It is reused by the single-cycle variant.

Test Plan:
- Reset, then `instr`=0x002081B3 (add x3,x1,x2), `mem_ready`=1 → FETCH, DECODE, EXECR(op 0), ALUWB(`RegWrite`=1); `retire` on cycle 4; `retired_cnt`=1.
- `instr`=0x402081B3 (sub) → EXECR drives `ALU_operation`=1; `instr` with `funct3`=010 R-type → ILLEGAL, `illegal`=1, held for 10 cycles, `retired_cnt` unchanged.
- `instr`=0x0040A283 (lw x5,4(x1)), `mem_ready` low 3 cycles in MEMREAD → MEMREAD held 4 cycles with `mem_req`=1, `AdrSrc`=1; MEMWB `ResultSrc`=1; total 8 cycles.
- `instr`=0x0050A423 (sw) → MEMWRITE `MemWrite`=1 until `mem_ready`; `RegWrite` never asserted.
- `instr`=0x00208463 (beq): `zero`=1 → `PCWrite`=1 in BRANCH; `zero`=0 → `PCWrite`=0; BNE (0x00209463) gives the inverse.
- `rst_n` low during MEMWRITE with `mem_ready`=0 → next cycle FETCH; `MemWrite`, `retire` never pulse; `retired_cnt`=0. Preset counter to all-ones then retire → wraps to 0.
